// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the 8N1 UART receiver: state encodings, reset level and default line timing.
// The UART_RX_PARITY_EN macro adds the PARITY state encoding.
package uart_rx_byte_pkg;

  localparam int unsigned DEF_CLK_FREQ = 100000000;
  localparam int unsigned DEF_BAUD     = 115200;
  localparam logic        RST_ACTIVE   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY  = 3'd3,
`endif
    ST_STOP    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

endpackage

// File: rtl/uart_rx_byte_sync.sv
// Two-flop synchronizer for the asynchronous RX line; reset value is a parameter so the
// line can be forced to its idle level during reset.
module uart_rx_sync
  import uart_rx_byte_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_d,
  output logic O_q
);

  logic meta;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst == RST_ACTIVE) begin
      meta <= RST_VAL;
      O_q  <= RST_VAL;
    end else begin
      meta <= I_d;
      O_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver holding the last good byte for the display driver.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
  parameter int unsigned BAUD         = DEF_BAUD,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD   = 1'b0
`endif
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_rx,
  output logic [7:0] O_data,
  output logic       O_valid,
  output logic       O_frame_err,
  output logic       O_parity_err,
  output logic       O_busy
);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx_byte: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] T_HALF = CNT_W'(HALF_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rxs;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .I_d   (I_rx),
    .O_q   (rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic par_pend;
  logic perr_q;
  assign O_parity_err = perr_q;
`else
  assign O_parity_err = 1'b0;
`endif

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst == RST_ACTIVE) begin
      state       <= ST_IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      O_data      <= 8'h00;
      O_valid     <= 1'b0;
      O_frame_err <= 1'b0;
      O_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend    <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      O_valid     <= 1'b0;
      O_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
      timer       <= timer + 1'b1;
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (!rxs) begin
            state  <= ST_START;
            O_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (timer == T_HALF) begin
            timer   <= '0;
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_pend <= 1'b0;
`endif
            // A start bit that is high again at mid-point was only a glitch.
            if (!rxs) begin
              state <= ST_DATA;
            end else begin
              state  <= ST_IDLE;
              O_busy <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (timer == T_LAST) begin
            timer   <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (timer == T_LAST) begin
            timer    <= '0;
            par_pend <= ((^shift) ^ rxs) != PARITY_ODD;
            state    <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (timer == T_LAST) begin
            timer <= '0;
            // Framing error wins over a pending parity error.
            if (!rxs) begin
              O_frame_err <= 1'b1;
              state       <= ST_RECOVER;
`ifdef UART_RX_PARITY_EN
            end else if (par_pend) begin
              perr_q <= 1'b1;
              state  <= ST_IDLE;
              O_busy <= 1'b0;
`endif
            end else begin
              O_data  <= shift;
              O_valid <= 1'b1;
              state   <= ST_IDLE;
              O_busy  <= 1'b0;
            end
          end
        end
        ST_RECOVER: begin
          timer <= '0;
          if (rxs) begin
            state  <= ST_IDLE;
            O_busy <= 1'b0;
          end
        end
        default: begin
          timer  <= '0;
          state  <= ST_IDLE;
          O_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at default line timing; covers the parity build when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_byte;

  localparam int C    = 100000000 / 115200;
  localparam int H    = C / 2;
  localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int LAT = 3 + H + (FB - 1) * C;

  logic       clk = 1'b0;
  logic       I_rst = 1'b1;
  logic       I_rx = 1'b1;
  logic [7:0] O_data;
  logic       O_valid, O_frame_err, O_parity_err, O_busy;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, overlap_cnt = 0, busy_bad = 0;
  int last_valid_cyc = 0, prev_valid_cyc = 0;
  int t_start = 0;
  int v0, f0, p0;

  uart_rx_byte dut (
    .I_clk        (clk),
    .I_rst        (I_rst),
    .I_rx         (I_rx),
    .O_data       (O_data),
    .O_valid      (O_valid),
    .O_frame_err  (O_frame_err),
    .O_parity_err (O_parity_err),
    .O_busy       (O_busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge
  always @(negedge clk) begin
    if (!I_rst) begin
      if (O_valid) begin
        valid_cnt++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        if (O_busy) busy_bad++;
      end
      if (O_frame_err) ferr_cnt++;
      if (O_parity_err) perr_cnt++;
      if (int'(O_valid) + int'(O_frame_err) + int'(O_parity_err) > 1) overlap_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  // Must be called right after a falling edge; leaves the line at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    t_start = cyc;
    I_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      I_rx = d[i];
      repeat (C) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    I_rx = par;
    repeat (C) @(negedge clk);
`endif
    I_rx = stop;
    repeat (C) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(O_data), 32'h00);
    check("rst_valid", 32'(O_valid), 0);
    check("rst_ferr", 32'(O_frame_err), 0);
    check("rst_perr", 32'(O_parity_err), 0);
    check("rst_busy", 32'(O_busy), 0);
    I_rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame 0xA5 with exact latency
    v0 = valid_cnt;
    send_frame(8'hA5, good_par(8'hA5), 1'b1);
    repeat (5) @(negedge clk);
    check("a5_count", 32'(valid_cnt), 32'(v0 + 1));
    check("a5_data", 32'(O_data), 32'hA5);
    check("a5_latency", 32'(last_valid_cyc - t_start), 32'(LAT));
    check("a5_busy_at_valid", 32'(busy_bad), 0);
    check("a5_busy_idle", 32'(O_busy), 0);

    // Back-to-back frames, no idle gap
    v0 = valid_cnt;
    send_frame(8'h3C, good_par(8'h3C), 1'b1);
    send_frame(8'hC3, good_par(8'hC3), 1'b1);
    repeat (5) @(negedge clk);
    check("b2b_count", 32'(valid_cnt), 32'(v0 + 2));
    check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(FB * C));
    check("b2b_data", 32'(O_data), 32'hC3);

    // Start-bit glitch shorter than half a bit
    v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    I_rx = 1'b0;
    repeat (200) @(negedge clk);
    I_rx = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_pulses", 32'(valid_cnt + ferr_cnt + perr_cnt), 32'(v0 + f0 + p0));
    check("glitch_busy", 32'(O_busy), 0);
    check("glitch_data", 32'(O_data), 32'hC3);

    // Bad stop bit followed by a break
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, good_par(8'h55), 1'b0);
    repeat (2000) @(negedge clk);
    check("ferr_count", 32'(ferr_cnt), 32'(f0 + 1));
    check("ferr_no_valid", 32'(valid_cnt), 32'(v0));
    check("ferr_data", 32'(O_data), 32'hC3);
    check("ferr_busy_break", 32'(O_busy), 1);
    I_rx = 1'b1;
    repeat (10) @(negedge clk);
    check("ferr_recover_idle", 32'(O_busy), 0);
    send_frame(8'h81, good_par(8'h81), 1'b1);
    repeat (5) @(negedge clk);
    check("after_ferr_count", 32'(valid_cnt), 32'(v0 + 1));
    check("after_ferr_data", 32'(O_data), 32'h81);
    check("after_ferr_ferr", 32'(ferr_cnt), 32'(f0 + 1));

    // Reset in the middle of the data bits
    I_rx = 1'b0;
    repeat (C) @(negedge clk);
    I_rx = 1'b1;
    repeat (3 * C) @(negedge clk);
    I_rst = 1'b1;
    #1;
    check("midrst_data", 32'(O_data), 32'h00);
    check("midrst_busy", 32'(O_busy), 0);
    check("midrst_valid", 32'(O_valid), 0);
    @(negedge clk);
    I_rst = 1'b0;
    repeat (20) @(negedge clk);
    v0 = valid_cnt;
    send_frame(8'h0F, good_par(8'h0F), 1'b1);
    repeat (5) @(negedge clk);
    check("midrst_next_count", 32'(valid_cnt), 32'(v0 + 1));
    check("midrst_next_data", 32'(O_data), 32'h0F);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("par_bad_perr", 32'(perr_cnt), 32'(p0 + 1));
    check("par_bad_novalid", 32'(valid_cnt), 32'(v0));
    check("par_bad_data", 32'(O_data), 32'h0F);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("par_good_valid", 32'(valid_cnt), 32'(v0 + 1));
    check("par_good_data", 32'(O_data), 32'h07);
    check("par_good_perr", 32'(perr_cnt), 32'(p0 + 1));
`else
    check("perr_tied_low", 32'(perr_cnt), 0);
`endif

    check("no_overlap", 32'(overlap_cnt), 0);
    check("busy_never_at_valid", 32'(busy_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
